// File: rtl/case2_pkg.sv
// Shared types and the per-lane case2 logic function
// used by the pipelined multi-lane case2 block.
package case2_pkg;

  localparam int MAX_LANES = 32;

  typedef enum logic {
    Z_LEGACY = 1'b0,
    Z_PARITY = 1'b1
  } z_mode_e;

  typedef struct packed {
    logic x;
    logic y;
    logic z;
  } c2_lane_t;

  typedef struct packed {
    logic [MAX_LANES-1:0] x;
    logic [MAX_LANES-1:0] y;
    logic [MAX_LANES-1:0] z;
  } c2_beat_t;

  function automatic c2_lane_t case2_eval(
    input logic    a,
    input logic    b,
    input logic    c,
    input logic    d,
    input logic    e,
    input z_mode_e mode
  );
    c2_lane_t r;
    logic     p;
    r.x = a & b & ~e & (c | d);
    r.y = ~(a & b & c & d & e);
    p   = b ^ c ^ d ^ e;
    // legacy z keeps the original cone shape
    r.z = (mode == Z_PARITY) ? p : (p | r.x | r.y);
    return r;
  endfunction

endpackage

// File: rtl/case2_pipe_if.sv
// Valid/ready beat bundle between the stimulus source,
// the case2 pipeline and the comparison stage.
interface case2_pipe_if #(
  parameter int LANES = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [LANES-1:0] in_a;
  logic [LANES-1:0] in_b;
  logic [LANES-1:0] in_c;
  logic [LANES-1:0] in_d;
  logic [LANES-1:0] in_e;
  logic             z_mode;
  logic             out_valid;
  logic             out_ready;
  logic [LANES-1:0] out_x;
  logic [LANES-1:0] out_y;
  logic [LANES-1:0] out_z;

  modport master (
    output in_valid, in_a, in_b, in_c, in_d, in_e,
    output z_mode, out_ready,
    input  in_ready, out_valid, out_x, out_y, out_z
  );

  modport slave (
    input  in_valid, in_a, in_b, in_c, in_d, in_e,
    input  z_mode, out_ready,
    output in_ready, out_valid, out_x, out_y, out_z
  );
endinterface

// File: rtl/case2_slice.sv
// One valid/data pipeline register; loads when ld_i is set,
// data only captured for valid beats so it holds when empty.
module case2_slice #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld_i,
  input  logic         valid_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  logic         valid_q;
  logic [W-1:0] data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (ld_i) begin
      valid_q <= valid_i;
      if (valid_i) data_q <= data_i;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/case2_pipe.sv
// Multi-lane pipelined case2 evaluator with backpressure
// and saturating hit/beat statistics.
module case2_pipe
  import case2_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int STAGES = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  case2_pipe_if.slave      bus,
  output logic [CNT_W-1:0] x_cnt,
  output logic [CNT_W-1:0] beat_cnt
);

  localparam int W    = 3 * LANES;
  localparam int PC_W = $clog2(LANES + 1);
  localparam int SW   = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
  localparam logic [CNT_W-1:0] CMAX = {CNT_W{1'b1}};

  logic [LANES-1:0] ex, ey, ez;
  c2_lane_t         r;

  always_comb begin
    ex = '0;
    ey = '0;
    ez = '0;
    r  = '0;
    for (int i = 0; i < LANES; i++) begin
      r = case2_eval(bus.in_a[i], bus.in_b[i], bus.in_c[i],
                     bus.in_d[i], bus.in_e[i],
                     z_mode_e'(bus.z_mode));
      ex[i] = r.x;
      ey[i] = r.y;
      ez[i] = r.z;
    end
  end

  logic [STAGES-1:0] vld;
  logic [STAGES:0]   ld;
  logic [STAGES-1:0] sv;
  logic [W-1:0]      sd  [STAGES];
  logic [W-1:0]      dat [STAGES];
  logic              hs;

  assign hs = bus.out_valid & bus.out_ready;

  // a slice may load when empty or when its successor drains it
  always_comb begin
    ld         = '0;
    ld[STAGES] = hs;
    for (int k = STAGES - 1; k >= 0; k--)
      ld[k] = ~vld[k] | ld[k+1];
  end

  always_comb begin
    sv    = '0;
    sv[0] = bus.in_valid;
    sd[0] = {ex, ey, ez};
    for (int k = 1; k < STAGES; k++) begin
      sv[k] = vld[k-1];
      sd[k] = dat[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    case2_slice #(.W(W)) u_slice (
      .clk     (clk),
      .rst     (rst),
      .ld_i    (ld[k]),
      .valid_i (sv[k]),
      .data_i  (sd[k]),
      .valid_o (vld[k]),
      .data_o  (dat[k])
    );
  end

  assign bus.in_ready  = ld[0] & ~rst;
  assign bus.out_valid = vld[STAGES-1];
  assign {bus.out_x, bus.out_y, bus.out_z} = dat[STAGES-1];

  logic [PC_W-1:0]  pc;
  logic [SW-1:0]    xs;
  logic [CNT_W:0]   bs;
  logic [CNT_W-1:0] x_cnt_q, x_cnt_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

  always_comb begin
    pc = '0;
    for (int i = 0; i < LANES; i++)
      pc = pc + PC_W'(bus.out_x[i]);
    xs = SW'(x_cnt_q) + SW'(pc);
    bs = {1'b0, beat_cnt_q} + 1'b1;
    x_cnt_d    = (xs > SW'(CMAX)) ? CMAX : xs[CNT_W-1:0];
    beat_cnt_d = bs[CNT_W] ? CMAX : bs[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      x_cnt_q    <= '0;
      beat_cnt_q <= '0;
    end else if (hs) begin
      x_cnt_q    <= x_cnt_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign x_cnt    = x_cnt_q;
  assign beat_cnt = beat_cnt_q;

endmodule

// File: tb/tb_case2_pipe.sv
// Scoreboard bench for case2_pipe: LANES=4, STAGES=2,
// CNT_W=4 so counter saturation is reachable quickly.
module tb_case2_pipe;

  logic       clk;
  logic       rst;
  logic       clr;
  logic [3:0] x_cnt;
  logic [3:0] beat_cnt;

  case2_pipe_if #(.LANES(4)) bus ();

  case2_pipe #(.LANES(4), .STAGES(2), .CNT_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .bus      (bus),
    .x_cnt    (x_cnt),
    .beat_cnt (beat_cnt)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  int          acc_cyc;
  int          out_cyc;
  logic        hs_in;
  logic        hs_out;
  logic [11:0] exp_q[$];
  logic [11:0] got_q[$];

  function automatic logic [11:0] model(
    input logic [3:0] a, b, c, d, e,
    input logic zm
  );
    logic [3:0] x, y, z;
    for (int i = 0; i < 4; i++) begin
      x[i] = a[i] && b[i] && !e[i] && (c[i] || d[i]);
      y[i] = !(a[i] && b[i] && c[i] && d[i] && e[i]);
      z[i] = zm ? (b[i] ^ c[i] ^ d[i] ^ e[i]) : y[i];
    end
    return {x, y, z};
  endfunction

  task automatic cycle(
    input logic v,
    input logic [3:0] a, b, c, d, e,
    input logic zm, ordy, r, cl
  );
    @(negedge clk);
    rst = r;
    clr = cl;
    bus.in_valid = v;
    bus.in_a = a;
    bus.in_b = b;
    bus.in_c = c;
    bus.in_d = d;
    bus.in_e = e;
    bus.z_mode = zm;
    bus.out_ready = ordy;
    #1;
    cyc++;
    hs_in  = v & bus.in_ready;
    hs_out = bus.out_valid & ordy;
    if (hs_in) begin
      exp_q.push_back(model(a, b, c, d, e, zm));
      acc_cyc = cyc;
    end
    if (hs_out) begin
      got_q.push_back({bus.out_x, bus.out_y, bus.out_z});
      out_cyc = cyc;
    end
  endtask

  task automatic idle(input logic ordy);
    cycle(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, ordy, 1'b0, 1'b0);
  endtask

  task automatic test_reset;
    cycle(1'b1, 4'hF, 4'hF, 4'hF, 4'hF, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 4'hF, 4'hF, 4'hF, 4'hF, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_in_ready got=%b exp=0", bus.in_ready);
    end
    idle(1'b1);
    checks++;
    if (bus.out_valid !== 1'b0 || x_cnt !== 4'd0 || beat_cnt !== 4'd0) begin
      errors++;
      $display("FAIL rst_state ov=%b xc=%0d bc=%0d exp 0/0/0",
               bus.out_valid, x_cnt, beat_cnt);
    end
    checks++;
    if ({bus.out_x, bus.out_y, bus.out_z} !== 12'h000) begin
      errors++;
      $display("FAIL rst_data got=%h exp=000",
               {bus.out_x, bus.out_y, bus.out_z});
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_latency;
    logic [11:0] g, e;
    cycle(1'b1, 4'b1111, 4'b1111, 4'b0101, 4'b0011, 4'b0000,
          1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (!hs_in) begin
      errors++;
      $display("FAIL lat_accept got=0 exp=1");
    end
    for (int t = 0; t < 8 && got_q.size() == 0; t++) idle(1'b1);
    checks++;
    if (got_q.size() != 1 || exp_q.size() != 1) begin
      errors++;
      $display("FAIL lat_count got=%0d exp=1", got_q.size());
    end else begin
      checks++;
      if (out_cyc - acc_cyc != 2) begin
        errors++;
        $display("FAIL lat_cycles got=%0d exp=2", out_cyc - acc_cyc);
      end
      g = got_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (g !== e || g !== 12'b0111_1111_1111) begin
        errors++;
        $display("FAIL lat_data got=%b exp=%b", g, e);
      end
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_zmode;
    logic [11:0] g;
    logic [11:0] req[4];
    req[0] = 12'b0000_1111_1111;
    req[1] = 12'b0000_1111_0000;
    req[2] = 12'b0001_0001_0001;
    req[3] = 12'b0001_0001_0001;
    cycle(1'b1, 4'h0, 4'hF, 4'hF, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 4'h0, 4'hF, 4'hF, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 4'hF, 4'hF, 4'hF, 4'hF, 4'hE, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 4'hF, 4'hF, 4'hF, 4'hF, 4'hE, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int t = 0; t < 10 && got_q.size() < 4; t++) idle(1'b1);
    checks++;
    if (got_q.size() != 4) begin
      errors++;
      $display("FAIL zmode_count got=%0d exp=4", got_q.size());
    end
    for (int i = 0; i < 4 && got_q.size() > 0; i++) begin
      g = got_q.pop_front();
      void'(exp_q.pop_front());
      checks++;
      if (g !== req[i]) begin
        errors++;
        $display("FAIL zmode_beat%0d got=%b exp=%b", i, g, req[i]);
      end
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_random;
    int k;
    logic [11:0] g, e;
    k = 0;
    for (int t = 0; t < 200 && k < 24; t++) begin
      cycle(1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom),
            4'($urandom), 4'($urandom), 4'($urandom),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'b0, 1'b0);
      if (hs_in) k++;
    end
    for (int t = 0; t < 10 && got_q.size() < exp_q.size(); t++)
      idle(1'b1);
    checks++;
    if (got_q.size() != exp_q.size() || k != 24) begin
      errors++;
      $display("FAIL rand_count got=%0d exp=%0d", got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL rand_data got=%b exp=%b", g, e);
      end
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_backpressure;
    int j;
    logic [11:0] snap, g, e;
    logic [3:0] jv;
    j = 0;
    snap = '0;
    for (int t = 0; t < 40 && (j < 10 || got_q.size() < 10); t++) begin
      jv = 4'(j);
      cycle(j < 10, 4'hF, 4'hF, jv, ~jv, {jv[0], jv[3:1]},
            jv[0], !(t >= 3 && t <= 7), 1'b0, 1'b0);
      if (hs_in) j++;
      if (t == 4) snap = {bus.out_x, bus.out_y, bus.out_z};
      if (t == 7) begin
        checks++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
          errors++;
          $display("FAIL bp_full in_ready=%b out_valid=%b exp 0/1",
                   bus.in_ready, bus.out_valid);
        end
        checks++;
        if ({bus.out_x, bus.out_y, bus.out_z} !== snap) begin
          errors++;
          $display("FAIL bp_stable got=%b exp=%b",
                   {bus.out_x, bus.out_y, bus.out_z}, snap);
        end
      end
    end
    checks++;
    if (got_q.size() != 10 || exp_q.size() != 10) begin
      errors++;
      $display("FAIL bp_count got=%0d exp=10", got_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL bp_order got=%b exp=%b", g, e);
      end
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_saturation;
    int k, mx, nb;
    logic pend;
    k = 0; mx = 0; nb = 0; pend = 0;
    idle(1'b1);
    cycle(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int t = 0; t < 14; t++) begin
      cycle(k < 5, 4'hF, 4'hF, 4'hF, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
      if (hs_in) k++;
      if (pend) begin
        checks++;
        if (x_cnt !== 4'(mx)) begin
          errors++;
          $display("FAIL sat_x_cnt got=%0d exp=%0d", x_cnt, mx);
        end
      end
      if (hs_out) begin
        mx = (mx + 4 > 15) ? 15 : mx + 4;
        nb++;
      end
      pend = hs_out;
    end
    checks++;
    if (beat_cnt !== 4'd5 || x_cnt !== 4'd15 || nb != 5) begin
      errors++;
      $display("FAIL sat_final bc=%0d xc=%0d beats=%0d exp 5/15/5",
               beat_cnt, x_cnt, nb);
    end
    cycle(1'b1, 4'hF, 4'hF, 4'hF, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    cycle(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1);
    checks++;
    if (!hs_out) begin
      errors++;
      $display("FAIL clr_hs got=0 exp=1");
    end
    idle(1'b1);
    checks++;
    if (x_cnt !== 4'd0 || beat_cnt !== 4'd0) begin
      errors++;
      $display("FAIL clr_cnt xc=%0d bc=%0d exp 0/0", x_cnt, beat_cnt);
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_reset_mid;
    logic [11:0] g;
    for (int t = 0; t < 4; t++)
      cycle(1'b1, 4'hF, 4'hF, 4'(t), 4'h1, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (beat_cnt === 4'd0) begin
      errors++;
      $display("FAIL rm_pre_cnt got=%0d exp=nonzero", beat_cnt);
    end
    cycle(1'b1, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 1'b0, 1'b0, 1'b1, 1'b1);
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL rm_in_ready got=%b exp=0", bus.in_ready);
    end
    exp_q.delete();
    got_q.delete();
    cycle(1'b1, 4'hF, 4'hF, 4'h3, 4'h0, 4'h1, 1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if (bus.out_valid !== 1'b0 || x_cnt !== 4'd0 || beat_cnt !== 4'd0 ||
        !hs_in) begin
      errors++;
      $display("FAIL rm_after ov=%b xc=%0d bc=%0d acc=%b exp 0/0/0/1",
               bus.out_valid, x_cnt, beat_cnt, hs_in);
    end
    for (int t = 0; t < 8 && got_q.size() == 0; t++) idle(1'b1);
    checks++;
    if (got_q.size() != 1 || out_cyc - acc_cyc != 2) begin
      errors++;
      $display("FAIL rm_latency got=%0d beats lat=%0d exp 1/2",
               got_q.size(), out_cyc - acc_cyc);
    end else begin
      g = got_q.pop_front();
      checks++;
      if (g !== model(4'hF, 4'hF, 4'h3, 4'h0, 4'h1, 1'b1)) begin
        errors++;
        $display("FAIL rm_data got=%b exp=%b", g,
                 model(4'hF, 4'hF, 4'h3, 4'h0, 4'h1, 1'b1));
      end
    end
    exp_q.delete();
    got_q.delete();
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    clr = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.in_c = '0;
    bus.in_d = '0;
    bus.in_e = '0;
    bus.z_mode = 1'b0;
    bus.out_ready = 1'b1;
    test_reset();
    test_latency();
    test_zmode();
    test_random();
    test_backpressure();
    test_saturation();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
